oled_spi_sched: RTL and testbench

Byte scheduler sitting directly above the OLED SPI byte writer. It sequences panel hardware reset and the fixed SSD1306 init command string, with an optional GRAM clear. It then shares the single writer with one client through a valid/ready request port. It drives the writer's `ena_write`/`data`, consumes its `write_done`, and owns the panel RES and DC pins.

---
 rtl/oled_pkg.sv | 45 ++++
 rtl/oled_init_rom.sv | 19 +
 rtl/oled_spi_sched.sv | 206 ++++++++++++++++++++
 tb/tb_oled_spi_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI scheduler: state encoding,
// SSD1306 init command string, D/C encodings and GRAM clear geometry.
package oled_pkg;

    typedef enum logic [3:0] {
        ST_RST_LOW    = 4'd0,
        ST_RST_WAIT   = 4'd1,
        ST_INIT_ISSUE = 4'd2,
        ST_INIT_WAIT  = 4'd3,
        ST_CLR_ISSUE  = 4'd4,
        ST_CLR_WAIT   = 4'd5,
        ST_IDLE       = 4'd6,
        ST_USR_ISSUE  = 4'd7,
        ST_USR_WAIT   = 4'd8
    } state_e;

    localparam int INIT_LEN = 25;

    localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int CLR_PAGES = 8;
    localparam int CLR_COLS  = 128;

    // Clear phase 0..2 are the page/column address commands, phase 3 streams zeros
    localparam logic [1:0] CLR_DATA_PHASE = 2'd3;

    function automatic logic [7:0] clr_cmd_byte(input logic [1:0] phase, input logic [2:0] page);
        logic [7:0] b;
        case (phase)
            2'd0:    b = 8'hB0 | {5'd0, page};
            2'd1:    b = 8'h00;
            2'd2:    b = 8'h10;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// Combinational lookup of the SSD1306 init command string by 5-bit index.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] rom_byte
);

    // Indices past the end of the string read as zero
    always_comb begin
        rom_byte = 8'h00;
        if (idx < 5'(INIT_LEN)) begin
            rom_byte = INIT_ROM[idx];
        end else begin
            rom_byte = 8'h00;
        end
    end

endmodule

// File: rtl/oled_spi_sched.sv
// Byte scheduler above the OLED SPI byte writer: panel reset, init string,
// optional GRAM clear (macro OLED_CLEAR_EN), then one valid/ready client.
module oled_spi_sched
    import oled_pkg::*;
#(
    parameter int RST_LOW_CYC  = 10000,
    parameter int RST_WAIT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_dc,
    input  logic [7:0] req_data,
    output logic       req_ready,
    input  logic       write_done,
    output logic       ena_write,
    output logic [7:0] data,
    output logic       oled_res,
    output logic       oled_dc,
    output logic       init_done
);

    localparam int RST_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int CNT_W   = $clog2(RST_MAX + 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [4:0]       IDX_LAST  = 5'(INIT_LEN - 1);

    state_e           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [4:0]       idx_r, idx_s;
    logic [7:0]       rom_byte_s, data_s;
    logic             dc_s, accept_s, issue_s;
`ifdef OLED_CLEAR_EN
    logic [1:0]       clr_phase_r, clr_phase_s;
    logic [6:0]       col_r, col_s;
    logic [2:0]       page_r, page_s;
`endif

    oled_init_rom u_init_rom (
        .idx      (idx_s),
        .rom_byte (rom_byte_s)
    );

    assign accept_s = req_valid & req_ready;
    assign issue_s  = (state_s == ST_INIT_ISSUE) | (state_s == ST_CLR_ISSUE) |
                      (state_s == ST_USR_ISSUE);

    // Next-state, reset counter and sequence index logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
`ifdef OLED_CLEAR_EN
        clr_phase_s = clr_phase_r;
        col_s       = col_r;
        page_s      = page_r;
`endif
        case (state_r)
            ST_RST_LOW: begin
                if (cnt_r == LOW_LAST) begin
                    state_s = ST_RST_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    state_s = ST_INIT_ISSUE;
                    cnt_s   = CNT_ZERO;
                    idx_s   = 5'd0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_INIT_ISSUE: state_s = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (write_done) begin
                    if (idx_r == IDX_LAST) begin
`ifdef OLED_CLEAR_EN
                        state_s     = ST_CLR_ISSUE;
                        clr_phase_s = 2'd0;
                        col_s       = 7'd0;
                        page_s      = 3'd0;
`else
                        state_s = ST_IDLE;
`endif
                    end else begin
                        idx_s   = idx_r + 5'd1;
                        state_s = ST_INIT_ISSUE;
                    end
                end else begin
                    state_s = ST_INIT_WAIT;
                end
            end
`ifdef OLED_CLEAR_EN
            ST_CLR_ISSUE: state_s = ST_CLR_WAIT;
            ST_CLR_WAIT: begin
                if (!write_done) begin
                    state_s = ST_CLR_WAIT;
                end else if (clr_phase_r != CLR_DATA_PHASE) begin
                    clr_phase_s = clr_phase_r + 2'd1;
                    state_s     = ST_CLR_ISSUE;
                end else if (col_r == 7'(CLR_COLS - 1)) begin
                    // Page end: column and page both wrap, page only after the last page
                    col_s       = 7'd0;
                    page_s      = page_r + 3'd1;
                    clr_phase_s = 2'd0;
                    state_s     = (page_r == 3'(CLR_PAGES - 1)) ? ST_IDLE : ST_CLR_ISSUE;
                end else begin
                    col_s   = col_r + 7'd1;
                    state_s = ST_CLR_ISSUE;
                end
            end
`endif
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_USR_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_USR_ISSUE: state_s = ST_USR_WAIT;
            ST_USR_WAIT: begin
                if (write_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_USR_WAIT;
                end
            end
            default: state_s = ST_RST_LOW;
        endcase
    end

    // Byte and D/C for the next issue; held otherwise so the writer sees stable values
    always_comb begin
        data_s = data;
        dc_s   = oled_dc;
        if (state_s == ST_INIT_ISSUE) begin
            data_s = rom_byte_s;
            dc_s   = DC_CMD;
        end
`ifdef OLED_CLEAR_EN
        else if (state_s == ST_CLR_ISSUE) begin
            if (clr_phase_s == CLR_DATA_PHASE) begin
                data_s = 8'h00;
                dc_s   = DC_DATA;
            end else begin
                data_s = clr_cmd_byte(clr_phase_s, page_s);
                dc_s   = DC_CMD;
            end
        end
`endif
        else if (accept_s) begin
            data_s = req_data;
            dc_s   = req_dc;
        end else begin
            data_s = data;
            dc_s   = oled_dc;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RST_LOW;
            cnt_r     <= CNT_ZERO;
            idx_r     <= 5'd0;
            data      <= 8'h00;
            oled_dc   <= 1'b0;
            ena_write <= 1'b0;
            oled_res  <= 1'b0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            data      <= data_s;
            oled_dc   <= dc_s;
            ena_write <= issue_s;
            oled_res  <= (state_s != ST_RST_LOW);
            req_ready <= (state_s == ST_IDLE);
            init_done <= init_done | (state_s == ST_IDLE);
        end
    end

`ifdef OLED_CLEAR_EN
    // GRAM clear position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_phase_r <= 2'd0;
            col_r       <= 7'd0;
            page_r      <= 3'd0;
        end else begin
            clr_phase_r <= clr_phase_s;
            col_r       <= col_s;
            page_r      <= page_s;
        end
    end
`endif

endmodule

// File: tb/tb_oled_spi_sched.sv
// Self-checking bench for oled_spi_sched with a behavioural 17-cycle byte writer.
module tb_oled_spi_sched;

    localparam int LOW_CYC  = 20;
    localparam int WAIT_CYC = 20;
    localparam int PERIOD   = 18;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_dc = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, write_done, ena_write, oled_res, oled_dc, init_done;
    logic [7:0] data;
    logic       wd_model = 1'b0;
    logic       wd_stray = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int c0 = 0;
    int init_rise = -1;
    int hs_count = 0;
    bit early_ready = 1'b0;

    logic [7:0] mon_data[$];
    logic       mon_dc[$];
    int         mon_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_dc[$];

    logic [7:0] rom_ref [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    logic [7:0] wr_data;
    logic       wr_dc;
    bit         wr_ok;

    assign write_done = wd_model | wd_stray;

    oled_spi_sched #(.RST_LOW_CYC(LOW_CYC), .RST_WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dc(req_dc),
        .req_data(req_data), .req_ready(req_ready), .write_done(write_done),
        .ena_write(ena_write), .data(data), .oled_res(oled_res),
        .oled_dc(oled_dc), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes as the DUT samples them
    always @(posedge clk) begin
        if (rst_n === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1) hs_count++;
    end

    // Byte / status monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ena_write === 1'b1) begin
            mon_data.push_back(data);
            mon_dc.push_back(oled_dc);
            mon_cyc.push_back(cyc);
        end
        if (init_done === 1'b1 && init_rise < 0) init_rise = cyc;
        if (rst_n === 1'b1 && init_done !== 1'b1 && req_ready === 1'b1) early_ready = 1'b1;
    end

    // Writer model: ena_write sampled at edge E returns write_done sampled at E+17
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ena_write === 1'b1) begin
                wr_data = data;
                wr_dc   = oled_dc;
                wr_ok   = 1'b1;
                for (int i = 0; i < 17; i++) begin
                    @(posedge clk);
                    if (rst_n !== 1'b1) wr_ok = 1'b0;
                end
                #1;
                if (wr_ok && rst_n === 1'b1) begin
                    checks++;
                    if (data !== wr_data || oled_dc !== wr_dc) begin
                        errors++;
                        $display("FAIL byte_stable data=%h dc=%b exp data=%h dc=%b", data, oled_dc, wr_data, wr_dc);
                    end
                    wd_model = 1'b1;
                    @(posedge clk);
                    #1 wd_model = 1'b0;
                end
            end
        end
    end

    task automatic build_expected();
        exp_data.delete();
        exp_dc.delete();
        for (int i = 0; i < 25; i++) begin
            exp_data.push_back(rom_ref[i]);
            exp_dc.push_back(1'b0);
        end
`ifdef OLED_CLEAR_EN
        for (int p = 0; p < 8; p++) begin
            exp_data.push_back(8'hB0 + 8'(p)); exp_dc.push_back(1'b0);
            exp_data.push_back(8'h00);         exp_dc.push_back(1'b0);
            exp_data.push_back(8'h10);         exp_dc.push_back(1'b0);
            for (int c = 0; c < 128; c++) begin
                exp_data.push_back(8'h00);
                exp_dc.push_back(1'b1);
            end
        end
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        mon_data.delete(); mon_dc.delete(); mon_cyc.delete();
        init_rise   = -1;
        early_ready = 1'b0;
        c0    = cyc;
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (req_ready !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_ready_timeout req_ready=%b exp=1", tag, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (oled_res !== 1'b0)  begin errors++; $display("FAIL reset_oled_res got=%b exp=0", oled_res); end
        if (oled_dc !== 1'b0)   begin errors++; $display("FAIL reset_oled_dc got=%b exp=0", oled_dc); end
        if (ena_write !== 1'b0) begin errors++; $display("FAIL reset_ena_write got=%b exp=0", ena_write); end
        if (data !== 8'h00)     begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    endtask

    task automatic test_reset_timing();
        int rise = -1;
        int first;
        release_reset();
        for (int i = 0; i < 80 && rise < 0; i++) begin
            @(negedge clk);
            if (oled_res === 1'b1) rise = cyc - c0;
        end
        checks++;
        if (rise != LOW_CYC) begin errors++; $display("FAIL res_low_cycles got=%0d exp=%0d", rise, LOW_CYC); end
        for (int i = 0; i < 80 && mon_data.size() == 0; i++) @(negedge clk);
        checks++;
        if (mon_data.size() == 0) begin
            errors++; $display("FAIL first_ena_timeout got=none exp=ena");
        end else begin
            first = mon_cyc[0] - c0;
            checks += 2;
            if (first < LOW_CYC + WAIT_CYC - 1 || first > LOW_CYC + WAIT_CYC + 1) begin
                errors++; $display("FAIL first_ena_cycle got=%0d exp=%0d+-1", first, LOW_CYC + WAIT_CYC);
            end
            if (mon_data[0] !== 8'hAE || mon_dc[0] !== 1'b0) begin
                errors++; $display("FAIL first_byte got=%h/%b exp=ae/0", mon_data[0], mon_dc[0]);
            end
        end
    endtask

    task automatic test_init_sequence();
        int n = exp_data.size();
        int budget = n * PERIOD + 200;
        int bad_d = 0, bad_dc = 0, bad_gap = 0;
        for (int i = 0; i < budget && (mon_data.size() < n || init_rise < 0); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (mon_data.size() != n || init_rise < 0) begin
            errors++;
            $display("FAIL init_count got=%0d rise=%0d exp=%0d", mon_data.size(), init_rise, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (mon_data[i] !== exp_data[i]) begin
                    if (bad_d == 0) $display("first data diff at %0d: got=%h exp=%h", i, mon_data[i], exp_data[i]);
                    bad_d++;
                end
                if (mon_dc[i] !== exp_dc[i]) bad_dc++;
                if (i > 0 && mon_cyc[i] - mon_cyc[i-1] != PERIOD) bad_gap++;
            end
            checks += 4;
            if (bad_d != 0)   begin errors++; $display("FAIL init_data bad=%0d exp=0", bad_d); end
            if (bad_dc != 0)  begin errors++; $display("FAIL init_dc bad=%0d exp=0", bad_dc); end
            if (bad_gap != 0) begin errors++; $display("FAIL init_period bad=%0d exp=0", bad_gap); end
            if (init_rise != mon_cyc[n-1] + PERIOD) begin
                errors++; $display("FAIL init_done_cycle got=%0d exp=%0d", init_rise, mon_cyc[n-1] + PERIOD);
            end
        end
        checks++;
        if (early_ready) begin errors++; $display("FAIL ready_before_init got=1 exp=0"); end
    endtask

    task automatic test_client();
        logic [7:0] d;
        logic       c;
        int t, n0, low;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            d = 8'($urandom);
            c = 1'($urandom_range(0, 1));
            if (i == 0) begin d = 8'h5A; c = 1'b1; end
            wait_ready("client");
            n0 = mon_data.size();
            t  = cyc;
            req_valid = 1'b1; req_data = d; req_dc = c;
            @(negedge clk);
            req_valid = 1'b0;
            low = 0;
            for (int j = 1; j <= 18; j++) begin
                if (req_ready !== 1'b1) low++;
                if (j < 18) @(negedge clk);
            end
            @(negedge clk);
            checks += 3;
            if (low != 18) begin errors++; $display("FAIL client_busy_cycles got=%0d exp=18", low); end
            if (req_ready !== 1'b1) begin errors++; $display("FAIL client_ready_t19 got=%b exp=1", req_ready); end
            if (mon_data.size() != n0 + 1) begin
                errors++; $display("FAIL client_byte_count got=%0d exp=%0d", mon_data.size() - n0, 1);
            end else begin
                checks++;
                if (mon_data[n0] !== d || mon_dc[n0] !== c || mon_cyc[n0] != t + 1) begin
                    errors++;
                    $display("FAIL client_byte got=%h/%b@%0d exp=%h/%b@%0d", mon_data[n0], mon_dc[n0], mon_cyc[n0], d, c, t + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [3];
        logic       c [3];
        int t_prev, n0;
        for (int i = 0; i < 3; i++) begin d[i] = 8'($urandom); c[i] = 1'($urandom_range(0, 1)); end
        wait_ready("b2b");
        n0 = mon_data.size();
        t_prev = cyc;
        req_valid = 1'b1; req_data = d[0]; req_dc = c[0];
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            req_data = d[i]; req_dc = c[i];
            wait_ready("b2b");
            checks++;
            if (cyc - t_prev != 19) begin errors++; $display("FAIL b2b_accept_gap got=%0d exp=19", cyc - t_prev); end
            t_prev = cyc;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (mon_data.size() != n0 + 3) begin
            errors++; $display("FAIL b2b_count got=%0d exp=3", mon_data.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mon_data[n0+i] !== d[i] || mon_dc[n0+i] !== c[i]) begin
                    errors++; $display("FAIL b2b_byte%0d got=%h/%b exp=%h/%b", i, mon_data[n0+i], mon_dc[n0+i], d[i], c[i]);
                end
            end
        end
    endtask

    task automatic test_stray_done();
        int n0;
        wait_ready("stray");
        n0 = mon_data.size();
        for (int i = 0; i < 3; i++) begin
            wd_stray = 1'b1;
            @(negedge clk);
            wd_stray = 1'b0;
            repeat (2) @(negedge clk);
        end
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL stray_ready got=%b exp=1", req_ready); end
        if (mon_data.size() != n0) begin errors++; $display("FAIL stray_bytes got=%0d exp=0", mon_data.size() - n0); end
    endtask

    task automatic test_reset_mid_byte();
        wait_ready("midrst");
        req_valid = 1'b1; req_data = 8'h3C; req_dc = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 6;
        if (oled_res !== 1'b0)  begin errors++; $display("FAIL midrst_oled_res got=%b exp=0", oled_res); end
        if (oled_dc !== 1'b0)   begin errors++; $display("FAIL midrst_oled_dc got=%b exp=0", oled_dc); end
        if (ena_write !== 1'b0) begin errors++; $display("FAIL midrst_ena got=%b exp=0", ena_write); end
        if (data !== 8'h00)     begin errors++; $display("FAIL midrst_data got=%h exp=00", data); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", req_ready); end
        if (init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done got=%b exp=0", init_done); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_valid_from_reset();
        int n = exp_data.size();
        int hs0;
        logic [7:0] d = 8'($urandom);
        req_valid = 1'b1; req_data = d; req_dc = 1'b1;
        hs0 = hs_count;
        release_reset();
        for (int i = 0; i < n * PERIOD + 300 && mon_data.size() < n + 2; i++) @(negedge clk);
        req_valid = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (mon_data.size() < n + 1 || init_rise < 0) begin
            errors++; $display("FAIL held_count got=%0d exp=%0d", mon_data.size(), n + 2);
        end else begin
            checks += 4;
            if (mon_data[0] !== 8'hAE) begin errors++; $display("FAIL restart_first got=%h exp=ae", mon_data[0]); end
            if (mon_data[n] !== d || mon_dc[n] !== 1'b1) begin
                errors++; $display("FAIL held_byte got=%h/%b exp=%h/1", mon_data[n], mon_dc[n], d);
            end
            if (mon_cyc[n] != init_rise + 1) begin
                errors++; $display("FAIL held_accept_cycle got=%0d exp=%0d", mon_cyc[n], init_rise + 1);
            end
            if (mon_data.size() - n != hs_count - hs0) begin
                errors++; $display("FAIL bytes_per_handshake got=%0d exp=%0d", mon_data.size() - n, hs_count - hs0);
            end
        end
        checks++;
        if (early_ready) begin errors++; $display("FAIL held_ready_early got=1 exp=0"); end
    endtask

    initial begin
        build_expected();
        test_reset();
        test_reset_timing();
        test_init_sequence();
        test_client();
        test_back_to_back();
        test_stray_done();
        test_reset_mid_byte();
        test_valid_from_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
